// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared state type and default geometry for the RAM loader.
package ram_loader_pkg;
   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 8;
   localparam int RAM_DEPTH = 2 ** DEF_ADDR_W;
   typedef enum logic [2:0] {IDLE, LOAD, FLUSH, VERIFY, FINISH} ldr_state_t;
endpackage

// File: rtl/ram_port_mux.sv
// ram_port_mux: hands the RAM ports to the CPU bus or to the loader, keyed on cpu_halt.
module ram_port_mux
   import ram_loader_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              cpu_halt,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic              cpu_w_en,
   input  logic [DATA_W-1:0] cpu_w_data,
   input  logic [ADDR_W-1:0] ldr_address,
   input  logic              ldr_prog_mode,
   input  logic [DATA_W-1:0] ldr_w_data,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_w_en,
   output logic              ram_prog_mode,
   output logic [DATA_W-1:0] ram_w_data
);
   // CPU writes are dropped, not deferred, while the loader owns the RAM
   assign ram_address   = cpu_halt ? ldr_address : cpu_address;
   assign ram_w_en      = !cpu_halt && cpu_w_en;
   assign ram_prog_mode = cpu_halt && ldr_prog_mode;
   assign ram_w_data    = cpu_halt ? ldr_w_data : cpu_w_data;
endmodule

// File: rtl/ram_loader.sv
// ram_loader: halts the CPU and streams a 16-byte image into the program RAM.
// Define RAM_LOADER_VERIFY_EN to add a read-back checksum verify pass.
module ram_loader
   import ram_loader_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic              cpu_w_en,
   input  logic [DATA_W-1:0] cpu_w_data,
   input  logic [DATA_W-1:0] ram_r_data,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_w_en,
   output logic              ram_prog_mode,
   output logic [ADDR_W-1:0] ram_prog_addr,
   output logic [DATA_W-1:0] ram_w_data,
   output logic              cpu_halt,
   output logic              busy,
   output logic              done,
   output logic              error
);
   localparam logic [2:0] S_IDLE   = IDLE;
   localparam logic [2:0] S_LOAD   = LOAD;
   localparam logic [2:0] S_FLUSH  = FLUSH;
   localparam logic [2:0] S_FINISH = FINISH;
   localparam logic [ADDR_W-1:0] LAST = '1;
   logic [2:0] state, next_state, flush_next;
   logic [ADDR_W-1:0] wcnt, prog_addr_q, ldr_address;
   logic [DATA_W-1:0] csum, wdata_q;
   logic prog_mode_q, error_q, accept, launch, verify_done;
   assign busy     = state != S_IDLE;
   assign cpu_halt = busy;
   assign in_ready = state == S_LOAD && !abort;
   assign accept   = in_valid && in_ready;
   assign launch   = state == S_IDLE && start;
   assign done     = state == S_FINISH && !error_q;
   assign error    = error_q;
   assign ram_prog_addr = prog_addr_q;
`ifdef RAM_LOADER_VERIFY_EN
   localparam logic [2:0] S_VERIFY = VERIFY;
   logic [ADDR_W:0] rcnt;
   logic [DATA_W-1:0] vsum;
   assign flush_next  = S_VERIFY;
   assign verify_done = rcnt[ADDR_W];
   assign ldr_address = rcnt[ADDR_W-1:0];
   // reads land one cycle late, so the count runs one past the last address
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rcnt    <= '0;
         vsum    <= '0;
         error_q <= 1'b0;
      end else if (launch) begin
         rcnt    <= '0;
         vsum    <= '0;
         error_q <= 1'b0;
      end else if (state == S_VERIFY && !abort) begin
         rcnt <= rcnt + 1'b1;
         vsum <= (rcnt != '0) ? vsum ^ ram_r_data : vsum;
         if (verify_done) error_q <= (vsum ^ ram_r_data) != csum;
      end
`else
   logic unused_r;
   assign unused_r    = ^ram_r_data;
   assign flush_next  = S_FINISH;
   assign verify_done = 1'b1;
   assign ldr_address = '0;
   assign error_q     = 1'b0;
`endif
   always_comb begin
      next_state = state;
      if (busy && abort) next_state = S_IDLE;
      else if (state == S_IDLE) next_state = start ? S_LOAD : S_IDLE;
      else if (state == S_LOAD) next_state = (accept && wcnt == LAST) ? S_FLUSH : S_LOAD;
      else if (state == S_FLUSH) next_state = flush_next;
      else if (state == S_FINISH) next_state = S_IDLE;
      else next_state = verify_done ? S_FINISH : state;
   end
   // the accepted byte is held one cycle so it lands on the RAM edge after acceptance
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state       <= S_IDLE;
         wcnt        <= '0;
         csum        <= '0;
         prog_mode_q <= 1'b0;
         prog_addr_q <= '0;
         wdata_q     <= '0;
      end else begin
         state       <= next_state;
         prog_mode_q <= accept;
         if (launch) begin
            wcnt <= '0;
            csum <= '0;
         end
         if (accept) begin
            prog_addr_q <= wcnt;
            wdata_q     <= in_data;
            wcnt        <= wcnt + 1'b1;
            csum        <= csum ^ in_data;
         end
      end
   ram_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
      .cpu_halt      (cpu_halt),
      .cpu_address   (cpu_address),
      .cpu_w_en      (cpu_w_en),
      .cpu_w_data    (cpu_w_data),
      .ldr_address   (ldr_address),
      .ldr_prog_mode (prog_mode_q),
      .ldr_w_data    (wdata_q),
      .ram_address   (ram_address),
      .ram_w_en      (ram_w_en),
      .ram_prog_mode (ram_prog_mode),
      .ram_w_data    (ram_w_data)
   );
endmodule
